pipe_stage_skid: RTL and testbench

Parametrised successor to the fixed IF/ID register. It is a generic inter-stage pipeline register carrying instruction, PC and PC+4 between any two stages (IF/ID, ID/EX, and so on).
- Adds a valid/ready handshake, a 2-entry skid buffer, synchronous flush and NOP bubble insertion, so stages can stall without combinational ready chains.
- One instance per stage boundary in the pipelined core.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/stage_payload_reg.sv | 21 ++
 rtl/pipe_stage_skid.sv | 136 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage register.
// State encoding doubles as the entry count (EMPTY=0, ONE=1, FULL=2).
package pipe_pkg;

  localparam int DEF_INSTR_W = 32;
  localparam int DEF_PC_W    = 32;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instruction;
    logic [DEF_PC_W-1:0]    pc;
    logic [DEF_PC_W-1:0]    pc_plus_4;
  } payload_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/stage_payload_reg.sv
// Width-parametrised payload register with synchronous reset and load enable.
module stage_payload_reg #(
  parameter int W = 96
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (reset)     data_q <= '0;
    else if (ld_i) data_q <= d_i;
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Optional perf counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(pipe_pkg::NOP_INSTR)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               up_valid_i,
  output logic               up_ready_o,
  input  logic [INSTR_W-1:0] instruction_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [PC_W-1:0]    pc_plus_4_i,
  output logic               dn_valid_o,
  input  logic               dn_ready_i,
  output logic [INSTR_W-1:0] instruction_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [PC_W-1:0]    pc_plus_4_o,
  output logic [1:0]         occupancy_o,
  output logic [31:0]        stall_cnt_o,
  output logic [31:0]        flush_cnt_o
);

  localparam int PW = INSTR_W + 2 * PC_W;

  typedef struct packed {
    logic [INSTR_W-1:0] instruction;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus_4;
  } stage_pay_t;

  logic [1:0] state_q, state_d;
  logic       accept, emit;
  logic       main_ld, skid_ld;
  stage_pay_t in_pay, main_d, main_q, skid_q;

  assign in_pay.instruction = instruction_i;
  assign in_pay.pc          = pc_i;
  assign in_pay.pc_plus_4   = pc_plus_4_i;

  // Ready depends on state only, so no ready chain runs through this stage.
  assign up_ready_o  = (state_q != pipe_pkg::ST_FULL);
  assign dn_valid_o  = (state_q != pipe_pkg::ST_EMPTY);
  assign occupancy_o = state_q;

  assign accept = up_valid_i & up_ready_o;
  assign emit   = dn_valid_o & dn_ready_i;

  always_comb begin
    state_d = state_q;
    main_ld = 1'b0;
    skid_ld = 1'b0;
    main_d  = in_pay;
    if (flush_i) begin
      state_d = pipe_pkg::ST_EMPTY;
    end else begin
      case (state_q)
        pipe_pkg::ST_EMPTY: begin
          if (accept) begin
            state_d = pipe_pkg::ST_ONE;
            main_ld = 1'b1;
          end
        end
        pipe_pkg::ST_ONE: begin
          if (accept && emit) begin
            main_ld = 1'b1;
          end else if (accept) begin
            state_d = pipe_pkg::ST_FULL;
            skid_ld = 1'b1;
          end else if (emit) begin
            state_d = pipe_pkg::ST_EMPTY;
          end
        end
        pipe_pkg::ST_FULL: begin
          if (emit) begin
            state_d = pipe_pkg::ST_ONE;
            main_ld = 1'b1;
            main_d  = skid_q;
          end
        end
        default: state_d = pipe_pkg::ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= pipe_pkg::ST_EMPTY;
    else       state_q <= state_d;
  end

  stage_payload_reg #(.W(PW)) u_main (
    .clk   (clk),
    .reset (reset),
    .ld_i  (main_ld),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  stage_payload_reg #(.W(PW)) u_skid (
    .clk   (clk),
    .reset (reset),
    .ld_i  (skid_ld),
    .d_i   (in_pay),
    .q_o   (skid_q)
  );

  // Invalid entries keep their data; only the instruction is masked.
  assign instruction_o = dn_valid_o ? main_q.instruction : NOP_INSTR;
  assign pc_o          = main_q.pc;
  assign pc_plus_4_o   = main_q.pc_plus_4;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (dn_valid_o && !dn_ready_i)
        stall_cnt_q <= pipe_pkg::sat_inc(stall_cnt_q);
      if (flush_i && (occupancy_o != 2'd0))
        flush_cnt_q <= pipe_pkg::sat_inc(flush_cnt_q);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: queue-based reference model plus literal checkpoints.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        reset, flush_i, up_valid_i, dn_ready_i;
  logic [31:0] instruction_i, pc_i, pc_plus_4_i;
  logic        up_ready_o, dn_valid_o;
  logic [31:0] instruction_o, pc_o, pc_plus_4_o;
  logic [1:0]  occupancy_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  localparam logic [31:0] NOP = 32'h0000_0013;

  pipe_stage_skid dut (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (flush_i),
    .up_valid_i    (up_valid_i),
    .up_ready_o    (up_ready_o),
    .instruction_i (instruction_i),
    .pc_i          (pc_i),
    .pc_plus_4_i   (pc_plus_4_i),
    .dn_valid_o    (dn_valid_o),
    .dn_ready_i    (dn_ready_i),
    .instruction_o (instruction_o),
    .pc_o          (pc_o),
    .pc_plus_4_o   (pc_plus_4_o),
    .occupancy_o   (occupancy_o),
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] pc4;
  } pay_t;

  pay_t        mq[$];
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two payloads.
  always @(posedge clk) begin : model
    bit   acc, emt;
    pay_t p;
    acc   = up_valid_i && (mq.size() < 2);
    emt   = (mq.size() > 0) && dn_ready_i;
    p.ins = instruction_i;
    p.pc  = pc_i;
    p.pc4 = pc_plus_4_i;
    if (reset) begin
      mq.delete();
      m_stall = 0;
      m_flush = 0;
    end else begin
      if ((mq.size() > 0) && !dn_ready_i) m_stall++;
      if (flush_i && (mq.size() != 0))    m_flush++;
      if (flush_i) mq.delete();
      else begin
        if (emt) void'(mq.pop_front());
        if (acc) mq.push_back(p);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_dn_valid", {31'd0, dn_valid_o}, {31'd0, mq.size() > 0});
      chk("m_up_ready", {31'd0, up_ready_o}, {31'd0, mq.size() < 2});
      chk("m_occupancy", {30'd0, occupancy_o}, mq.size());
      if (mq.size() > 0) begin
        chk("m_instr", instruction_o, mq[0].ins);
        chk("m_pc", pc_o, mq[0].pc);
        chk("m_pc4", pc_plus_4_o, mq[0].pc4);
      end else begin
        chk("m_instr_nop", instruction_o, NOP);
      end
`ifdef PIPE_STAGE_PERF_EN
      chk("m_stall_cnt", stall_cnt_o, m_stall);
      chk("m_flush_cnt", flush_cnt_o, m_flush);
`else
      chk("m_stall_cnt", stall_cnt_o, 32'd0);
      chk("m_flush_cnt", flush_cnt_o, 32'd0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    up_valid_i    = v;
    instruction_i = ins;
    pc_i          = pc;
    pc_plus_4_i   = pc + 32'd4;
  endtask

  initial begin
    reset   = 1'b1;
    flush_i = 1'b0;
    dn_ready_i = 1'b0;
    put(1'b1, 32'h00500093, 32'h0);
    tick();
    tick();
    chk_en = 1'b1;
    chk("rst_dn_valid", {31'd0, dn_valid_o}, 32'd0);
    chk("rst_up_ready", {31'd0, up_ready_o}, 32'd1);
    chk("rst_instr", instruction_o, 32'h00000013);
    chk("rst_occ", {30'd0, occupancy_o}, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    reset = 1'b0;

    // Back-to-back streaming with downstream always ready.
    dn_ready_i = 1'b1;
    put(1'b1, 32'h00500093, 32'h0);  tick();
    chk("strm0_instr", instruction_o, 32'h00500093);
    chk("strm0_occ", {30'd0, occupancy_o}, 32'd1);
    put(1'b1, 32'h00A00113, 32'h4);  tick();
    chk("strm1_instr", instruction_o, 32'h00A00113);
    chk("strm1_occ", {30'd0, occupancy_o}, 32'd1);
    put(1'b1, 32'h002081B3, 32'h8);  tick();
    chk("strm2_instr", instruction_o, 32'h002081B3);
    chk("strm2_pc4", pc_plus_4_o, 32'hC);
    put(1'b0, 32'h0, 32'h0);         tick();
    chk("strm_drain", {31'd0, dn_valid_o}, 32'd0);

    // Downstream stalled while three payloads are offered.
    dn_ready_i = 1'b0;
    put(1'b1, 32'h11111111, 32'h0);  tick();
    put(1'b1, 32'h22222222, 32'h4);  tick();
    chk("stall_occ2", {30'd0, occupancy_o}, 32'd2);
    chk("stall_rdy0", {31'd0, up_ready_o}, 32'd0);
    put(1'b1, 32'h33333333, 32'h8);  tick();
    chk("stall_hold_occ", {30'd0, occupancy_o}, 32'd2);
    chk("stall_hold_pc", pc_o, 32'h0);
    dn_ready_i = 1'b1;               tick();
    chk("rel_pc4", pc_o, 32'h4);
    tick();
    chk("rel_pc8", pc_o, 32'h8);
    chk("rel_instr8", instruction_o, 32'h33333333);
    put(1'b0, 32'h0, 32'h0);         tick();
    chk("rel_empty", {30'd0, occupancy_o}, 32'd0);

    // Flush from FULL with a payload offered in the same cycle.
    dn_ready_i = 1'b0;
    put(1'b1, 32'hAAAA0001, 32'h100); tick();
    put(1'b1, 32'hAAAA0002, 32'h104); tick();
    put(1'b1, 32'hAAAA0003, 32'h108);
    flush_i = 1'b1;                  tick();
    flush_i = 1'b0;
    put(1'b0, 32'h0, 32'h0);
    chk("fl_dn_valid", {31'd0, dn_valid_o}, 32'd0);
    chk("fl_occ", {30'd0, occupancy_o}, 32'd0);
    chk("fl_instr", instruction_o, NOP);
    dn_ready_i = 1'b1;               tick();
    tick();
    chk("fl_never_emit", {31'd0, dn_valid_o}, 32'd0);

    // Sustained accept+emit from ONE.
    put(1'b1, 32'hBBBB0000, 32'h200); tick();
    for (int i = 1; i <= 4; i++) begin
      put(1'b1, 32'hBBBB0000 + i, 32'h200 + 32'(4 * i));
      tick();
      chk("ae_occ", {30'd0, occupancy_o}, 32'd1);
      chk("ae_pc", pc_o, 32'h200 + 32'(4 * i));
    end
    put(1'b0, 32'h0, 32'h0);         tick();

    // Reset mid-operation with a handshake pending.
    put(1'b1, 32'hCCCC0000, 32'h300);
    dn_ready_i = 1'b0;               tick();
    reset = 1'b1;                    tick();
    chk("mid_rst_valid", {31'd0, dn_valid_o}, 32'd0);
    chk("mid_rst_occ", {30'd0, occupancy_o}, 32'd0);
    reset = 1'b0;
    put(1'b0, 32'h0, 32'h0);

    // Counter scenario: 5 stall cycles, then one flush at occupancy 2.
    put(1'b1, 32'hDDDD0000, 32'h400); tick();
    put(1'b1, 32'hDDDD0001, 32'h404); tick();
    put(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    chk("perf_pre_occ", {30'd0, occupancy_o}, 32'd2);
    flush_i    = 1'b1;
    dn_ready_i = 1'b1;               tick();
    flush_i    = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
    chk("perf_stall", stall_cnt_o, 32'd5);
    chk("perf_flush", flush_cnt_o, 32'd1);
`else
    chk("perf_stall_off", stall_cnt_o, 32'd0);
    chk("perf_flush_off", flush_cnt_o, 32'd0);
`endif
    flush_i = 1'b1;                  tick();
    flush_i = 1'b0;                  tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
